// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, parity and stop-bit modes,
// and a parity helper that only covers the configured number of data bits.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [2:0] PAR_NONE  = 3'd0;
    localparam logic [2:0] PAR_ODD   = 3'd1;
    localparam logic [2:0] PAR_EVEN  = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;

    localparam logic [1:0] STOP_1   = 2'd0;
    localparam logic [1:0] STOP_1P5 = 2'd1;
    localparam logic [1:0] STOP_2   = 2'd2;

    // Parity over the low nbits of data; bits above nbits never contribute.
    function automatic logic calc_parity(input logic [15:0] data,
                                         input logic [3:0]  nbits,
                                         input logic [2:0]  mode);
        logic x;
        x = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(nbits)) x = x ^ data[i];
        end
        case (mode)
            PAR_ODD:  return ~x;
            PAR_EVEN: return x;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts sample_ticks up to a programmable terminal count and strobes
// bit_end on the tick that completes the period. restart holds it at zero.
module uart_bit_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             sample_tick,
    input  logic             restart,
    input  logic [CNT_W-1:0] term_cnt,
    output logic             bit_end
);

    logic [CNT_W-1:0] cnt;

    assign bit_end = !restart && sample_tick && (cnt == term_cnt);

    // Tick counter: cleared on restart or at the end of each period.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!resetn) begin
            cnt <= '0;
        end else if (restart || bit_end) begin
            cnt <= '0;
        end else if (sample_tick) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Runtime-configurable UART transmitter: start, 5..DATA_W data bits LSB
// first, optional parity, 1/1.5/2 stop bits. Configuration is captured at
// word acceptance. Optional macro UART_TX_CTS_EN adds a cts_n flow-control
// input that gates s_ready.
module uart_tx_param #(
    parameter int DATA_W     = 9,
    parameter int OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              resetn,
`ifdef UART_TX_CTS_EN
    input  logic              cts_n,
`endif
    input  logic              sample_tick,
    input  logic [3:0]        cfg_data_bits,
    input  logic [2:0]        cfg_parity,
    input  logic [1:0]        cfg_stop,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              busy,
    output logic              tx_done,
    output logic              tx
);

    import uart_pkg::*;

    localparam int CNT_W = $clog2(2 * OVERSAMPLE);
    localparam logic [CNT_W-1:0] TC_BIT  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] TC_1P5  = CNT_W'((3 * OVERSAMPLE) / 2 - 1);
    localparam logic [CNT_W-1:0] TC_2    = CNT_W'(2 * OVERSAMPLE - 1);

    logic [2:0]        state;
    logic [DATA_W-1:0] shift_reg;
    logic [3:0]        bit_idx;
    logic [3:0]        n_bits;
    logic [2:0]        par_mode;
    logic              par_bit;
    logic [1:0]        stop_mode;
    logic              ready_q;
    logic              cts_ok;
    logic              handshake;
    logic              bit_end;
    logic [CNT_W-1:0]  term_cnt;

    logic [3:0]        cfg_bits_c;
    logic [2:0]        cfg_par_c;
    logic [1:0]        cfg_stop_c;
    logic [DATA_W-1:0] data_masked;

`ifdef UART_TX_CTS_EN
    logic cts_meta;
    logic cts_sync;

    // Two-flop synchroniser for the asynchronous clear-to-send input.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cts_meta <= 1'b1;
            cts_sync <= 1'b1;
        end else begin
            cts_meta <= cts_n;
            cts_sync <= cts_meta;
        end
    end

    assign cts_ok = ~cts_sync;
`else
    assign cts_ok = 1'b1;
`endif

    assign s_ready   = ready_q && cts_ok;
    assign handshake = s_valid && s_ready;
    assign busy      = (state != ST_IDLE);

    // Clamp the live configuration and mask the word to the used bits.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        cfg_bits_c  = cfg_data_bits;
        cfg_par_c   = cfg_parity;
        cfg_stop_c  = cfg_stop;
        data_masked = '0;
        if (cfg_data_bits < 4'd5)               cfg_bits_c = 4'd5;
        else if (cfg_data_bits > 4'(DATA_W))    cfg_bits_c = 4'(DATA_W);
        if (cfg_parity > PAR_SPACE)             cfg_par_c  = PAR_NONE;
        if (cfg_stop == 2'd3)                   cfg_stop_c = STOP_2;
        for (int i = 0; i < DATA_W; i++) begin
            data_masked[i] = s_data[i] && (i < int'(cfg_bits_c));
        end
    end

    // Stop bits use a longer period; every other state is one bit period.
    always_comb begin
        term_cnt = TC_BIT;
        if (state == ST_STOP) begin
            case (stop_mode)
                STOP_1P5: term_cnt = TC_1P5;
                STOP_2:   term_cnt = TC_2;
                default:  term_cnt = TC_BIT;
            endcase
        end
    end

    uart_bit_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk         (clk),
        .resetn      (resetn),
        .sample_tick (sample_tick),
        .restart     (state == ST_IDLE),
        .term_cnt    (term_cnt),
        .bit_end     (bit_end)
    );

    // Frame sequencer: tx is registered and always reflects the next bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            n_bits    <= '0;
            par_mode  <= PAR_NONE;
            par_bit   <= 1'b0;
            stop_mode <= STOP_1;
            ready_q   <= 1'b0;
            tx_done   <= 1'b0;
            tx        <= 1'b1;
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx      <= 1'b1;
                    ready_q <= ~handshake;
                    if (handshake) begin
                        shift_reg <= data_masked;
                        n_bits    <= cfg_bits_c;
                        par_mode  <= cfg_par_c;
                        par_bit   <= calc_parity(16'(data_masked), cfg_bits_c, cfg_par_c);
                        stop_mode <= cfg_stop_c;
                        bit_idx   <= '0;
                        tx        <= 1'b0;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        bit_idx <= '0;
                        tx      <= shift_reg[0];
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == n_bits - 4'd1) begin
                            if (par_mode != PAR_NONE) begin
                                tx    <= par_bit;
                                state <= ST_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            shift_reg <= shift_reg >> 1;
                            tx        <= shift_reg[1];
                            bit_idx   <= bit_idx + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        tx    <= 1'b1;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        tx_done <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: the stimulus side queues the frame it
// expects at each acceptance; the monitor captures tx once per counted
// sample_tick and compares the whole frame when tx_done pulses.
module tb_uart_tx_param;

    localparam int OS = 16;
    localparam int DW = 9;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          sample_tick = 1'b0;
    logic [3:0]    cfg_data_bits = 4'd8;
    logic [2:0]    cfg_parity = 3'd0;
    logic [1:0]    cfg_stop = 2'd0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          busy;
    logic          tx_done;
    logic          tx;

    always #5 clk = ~clk;

    uart_tx_param #(
        .DATA_W     (DW),
        .OVERSAMPLE (OS)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .sample_tick   (sample_tick),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop      (cfg_stop),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .busy          (busy),
        .tx_done       (tx_done),
        .tx            (tx)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            nb;
        int            pm;
        int            sticks;
    } frame_t;

    frame_t exp_q[$];
    logic   got_q[$];
    int     n_tests = 0;
    int     n_fail = 0;
    int     done_cnt = 0;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: what a frame with these settings must look like on the line.
    function automatic frame_t model(input logic [3:0] bits, input logic [2:0] par,
                                     input logic [1:0] stop, input logic [DW-1:0] d);
        frame_t f;
        f.nb     = (int'(bits) < 5) ? 5 : ((int'(bits) > DW) ? DW : int'(bits));
        f.pm     = (int'(par) > 4) ? 0 : int'(par);
        f.sticks = (stop == 2'd0) ? OS : ((stop == 2'd1) ? (OS * 3) / 2 : 2 * OS);
        f.data   = d;
        return f;
    endfunction

    task automatic compare_frame(input frame_t f);
        logic exp_t[$];
        int   ones;
        logic pbit;
        int   nmis;
        ones = 0;
        for (int i = 0; i < f.nb; i++) ones += int'(f.data[i]);
        case (f.pm)
            1:       pbit = (ones % 2 == 0);
            2:       pbit = (ones % 2 == 1);
            3:       pbit = 1'b1;
            default: pbit = 1'b0;
        endcase
        repeat (OS) exp_t.push_back(1'b0);
        for (int i = 0; i < f.nb; i++) repeat (OS) exp_t.push_back(f.data[i]);
        if (f.pm != 0) repeat (OS) exp_t.push_back(pbit);
        repeat (f.sticks) exp_t.push_back(1'b1);
        check("frame_ticks", got_q.size(), exp_t.size());
        nmis = 0;
        for (int i = 0; i < exp_t.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_t[i]) nmis++;
        end
        check("frame_bit_errors", nmis, 0);
    endtask

    // Baud generator model: one sample_tick every 4 clk cycles.
    initial begin
        int tcnt;
        tcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            tcnt++;
            sample_tick = (tcnt % 4 == 0);
        end
    end

    // Monitor: collect per-tick line levels and score each completed frame.
    initial begin : monitor
        logic   done_prev;
        frame_t f;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                got_q.delete();
                done_prev = 1'b0;
            end else begin
                if (done_prev) begin
                    check("done_one_cycle", int'(tx_done), 0);
                    check("idle_tx_high", int'(tx), 1);
                    if (s_valid) check("ready_after_done", int'(s_ready), 1);
                end
                if (busy && sample_tick) got_q.push_back(tx);
                if (tx_done) begin
                    done_cnt++;
                    check("ready_low_at_done", int'(s_ready), 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        f = exp_q.pop_front();
                        compare_frame(f);
                    end
                    got_q.delete();
                end
                done_prev = tx_done;
            end
        end
    end

    // Present one word, wait for acceptance, queue its expected frame.
    // gap > 0 drops s_valid and scrambles config/data while the frame runs.
    task automatic send(input logic [3:0] bits, input logic [2:0] par,
                        input logic [1:0] stop, input logic [DW-1:0] d, input int gap);
        bit ok;
        cfg_data_bits = bits;
        cfg_parity    = par;
        cfg_stop      = stop;
        s_data        = d;
        s_valid       = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (s_ready && s_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("handshake_timeout", 0, 1);
        end else begin
            exp_q.push_back(model(bits, par, stop, d));
        end
        @(posedge clk);
        #1;
        if (gap > 0) begin
            s_valid       = 1'b0;
            cfg_data_bits = 4'($urandom_range(0, 15));
            cfg_parity    = 3'($urandom_range(0, 7));
            cfg_stop      = 2'($urandom_range(0, 3));
            s_data        = DW'($urandom);
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int snap;
        bit drained;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", int'(tx), 1);
        check("reset_s_ready", int'(s_ready), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_tx_done", int'(tx_done), 0);
        resetn = 1'b1;

        // Directed frames: 8N1, 7E1, 7O1, 1.5 stop, illegal stop 3,
        // clamped bit count with parity scrambled mid-frame, back-to-back.
        send(4'd8, 3'd0, 2'd0, 9'h055, 0);
        send(4'd7, 3'd2, 2'd0, 9'h041, 0);
        send(4'd7, 3'd1, 2'd0, 9'h041, 900);
        send(4'd8, 3'd0, 2'd1, 9'h0A3, 0);
        send(4'd8, 3'd0, 2'd3, 9'h0A3, 900);
        send(4'd3, 3'd0, 2'd0, 9'h01F, 900);
        send(4'd9, 3'd3, 2'd0, 9'h1FF, 0);
        send(4'd15, 3'd6, 2'd2, 9'h12C, 0);

        for (int n = 0; n < 14; n++) begin
            int g;
            g = ($urandom_range(0, 2) == 0) ? 900 : (($urandom_range(0, 1) == 0) ? 0 : 5);
            send(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), DW'($urandom), g);
        end
        s_valid = 1'b0;

        drained = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        check("drain", int'(drained), 1);
        @(posedge clk);
        #1;

        // Mid-frame reset: all-zero data keeps tx low in DATA beforehand.
        send(4'd8, 3'd0, 2'd0, 9'h000, 0);
        s_valid = 1'b0;
        repeat (OS * 4 * 2 + 10) @(posedge clk);
        #1;
        check("pre_reset_tx", int'(tx), 0);
        check("pre_reset_busy", int'(busy), 1);
        snap = done_cnt;
        resetn = 1'b0;
        exp_q.delete();
        #1;
        check("abort_tx", int'(tx), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_s_ready", int'(s_ready), 0);
        check("abort_tx_done", int'(tx_done), 0);
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        check("no_done_after_abort", done_cnt, snap);
        check("idle_after_abort", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
